ro_sampler: RTL and testbench

RO_SAMPLER -- requirements
Module: ro_sampler

---
 rtl/ro_sampler.sv | 151 +++++++++++++++
 tb/tb_ro_sampler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ro_sampler.sv
// Ring-oscillator entropy sampler: synchronizes and XORs the oscillator outputs,
// decimates to raw bits, applies von Neumann debiasing and packs bytes behind a valid/ready port.
module ro_sampler #(
  parameter int RO_COUNT      = 4,
  parameter int SAMPLE_DIV    = 16,
  parameter int WARMUP_CYCLES = 256,
  parameter int STUCK_LIMIT   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [RO_COUNT-1:0] roIn,
  output logic                roEnable,
  output logic [7:0]          dataOut,
  output logic                dataValid,
  input  logic                dataReady,
  output logic                stuckError
);

  typedef enum logic [1:0] {IDLE, WARMUP, SAMPLE, ERROR} state_t;

  state_t              state;
  logic [RO_COUNT-1:0] roSync1;
  logic [RO_COUNT-1:0] roSync2;
  logic [15:0]         warmCnt;
  logic [15:0]         sampleCnt;
  logic [9:0]          stuckCnt;
  logic                lastBit;
  logic                havePair;
  logic                pairBit;
  logic [7:0]          asmReg;
  logic [3:0]          asmCnt;

  logic                rawBit;
  logic                captureNow;
  logic [9:0]          stuckNext;
  logic                stuckTrip;
  logic                emitValid;
  logic                asmFull;
  logic                moveByte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roSync1 <= '0;
      roSync2 <= '0;
    end else begin
      roSync1 <= roIn;
      roSync2 <= roSync1;
    end
  end

  assign rawBit     = ^roSync2;
  assign captureNow = (state == SAMPLE) && (sampleCnt == 16'(SAMPLE_DIV - 1));
  // A run restarts at 1 on the first capture of a SAMPLE visit or on any change.
  assign stuckNext  = (stuckCnt == 10'd0 || rawBit != lastBit) ? 10'd1 : stuckCnt + 10'd1;
  assign stuckTrip  = captureNow && (stuckNext == 10'(STUCK_LIMIT));
  assign emitValid  = captureNow && havePair && (pairBit != rawBit);
  assign asmFull    = (asmCnt == 4'd8);
  assign moveByte   = (state == SAMPLE) && asmFull && (!dataValid || dataReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      roEnable   <= 1'b0;
      dataOut    <= 8'h00;
      dataValid  <= 1'b0;
      stuckError <= 1'b0;
      warmCnt    <= '0;
      sampleCnt  <= '0;
      stuckCnt   <= '0;
      lastBit    <= 1'b0;
      havePair   <= 1'b0;
      pairBit    <= 1'b0;
      asmReg     <= '0;
      asmCnt     <= '0;
    end else begin
      if (dataValid && dataReady) dataValid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WARMUP;
            roEnable <= 1'b1;
            warmCnt  <= '0;
          end
        end
        WARMUP: begin
          if (!start) begin
            state    <= IDLE;
            roEnable <= 1'b0;
          end else if (warmCnt == 16'(WARMUP_CYCLES - 1)) begin
            state     <= SAMPLE;
            sampleCnt <= '0;
            stuckCnt  <= '0;
            havePair  <= 1'b0;
            asmReg    <= '0;
            asmCnt    <= '0;
          end else begin
            warmCnt <= warmCnt + 16'd1;
          end
        end
        SAMPLE: begin
          if (stuckTrip) begin
            state      <= ERROR;
            roEnable   <= 1'b0;
            stuckError <= 1'b1;
            dataValid  <= 1'b0;
            asmReg     <= '0;
            asmCnt     <= '0;
            havePair   <= 1'b0;
          end else if (!start) begin
            state     <= IDLE;
            roEnable  <= 1'b0;
            sampleCnt <= '0;
            havePair  <= 1'b0;
            asmReg    <= '0;
            asmCnt    <= '0;
          end else begin
            sampleCnt <= captureNow ? 16'd0 : sampleCnt + 16'd1;
            if (captureNow) begin
              lastBit  <= rawBit;
              stuckCnt <= stuckNext;
              havePair <= !havePair;
              pairBit  <= rawBit;
            end
            // A full assembly byte blocks new bits until it moves out.
            if (emitValid && !asmFull) begin
              asmReg <= {asmReg[6:0], pairBit};
              asmCnt <= asmCnt + 4'd1;
            end
            if (moveByte) begin
              dataOut   <= asmReg;
              dataValid <= 1'b1;
              asmReg    <= '0;
              asmCnt    <= '0;
            end
          end
        end
        ERROR: begin
          roEnable   <= 1'b0;
          stuckError <= 1'b1;
          dataValid  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          roEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_sampler.sv
// Directed bench for ro_sampler: drives whole sample periods of a chosen raw bit
// (XOR parity spread over all oscillator inputs) and checks bytes, handshake, stop and stuck behaviour.
module tb_ro_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] roIn;
  logic       roEnable;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady;
  logic       stuckError;

  int         checkCount = 0;
  int         passCount  = 0;
  logic [2:0] rot        = 3'd0;
  logic [7:0] pat;

  ro_sampler #(
    .RO_COUNT(4),
    .SAMPLE_DIV(16),
    .WARMUP_CYCLES(256),
    .STUCK_LIMIT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .roIn(roIn),
    .roEnable(roEnable),
    .dataOut(dataOut),
    .dataValid(dataValid),
    .dataReady(dataReady),
    .stuckError(stuckError)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
  endtask

  // The raw bit is the parity of all inputs; the upper bits rotate so every input toggles.
  task automatic driveRaw(input logic b);
    rot  = rot + 3'd1;
    roIn = {rot, b ^ (^rot)};
  endtask

  task automatic applyStimulus(input logic b);
    driveRaw(b);
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic sendEmit(input logic e);
    applyStimulus(e);
    applyStimulus(~e);
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) sendEmit(v[i]);
  endtask

  // One raw-0 period with a single-cycle accept, followed by another raw 0 so the pair emits nothing.
  task automatic acceptPair(input string tag, input logic expValid, input logic [7:0] expData);
    driveRaw(1'b0);
    dataReady = 1'b1;
    @(posedge clk);
    #1;
    dataReady = 1'b0;
    checkOutput({tag, "Valid"}, {7'b0, dataValid}, {7'b0, expValid});
    if (expValid) checkOutput({tag, "Data"}, dataOut, expData);
    repeat (15) @(posedge clk);
    #1;
    applyStimulus(1'b0);
  endtask

  // Leaves the bench 8 cycles before the first capture edge of the new SAMPLE visit.
  task automatic startSession(input string tag);
    logic got;
    got   = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (roEnable) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, "Enable"}, {7'b0, got}, 8'h01);
    repeat (264) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b1;
    dataReady = 1'b0;
    roIn      = 4'b0000;
    repeat (6) begin
      @(negedge clk);
      roIn = roIn ^ 4'b1011;
    end
    checkOutput("rstEnable", {7'b0, roEnable}, 8'h00);
    checkOutput("rstValid", {7'b0, dataValid}, 8'h00);
    checkOutput("rstData", dataOut, 8'h00);
    checkOutput("rstStuck", {7'b0, stuckError}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    startSession("s1");
    pat = 8'h55;
    for (int i = 7; i >= 1; i--) sendEmit(pat[i]);
    checkOutput("byteEarlyValid", {7'b0, dataValid}, 8'h00);
    sendEmit(pat[0]);
    checkOutput("byteValid", {7'b0, dataValid}, 8'h01);
    checkOutput("byteData", dataOut, 8'h55);
    acceptPair("accept55", 1'b0, 8'h00);

    repeat (20) begin
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
    end
    checkOutput("discardValid", {7'b0, dataValid}, 8'h00);
    checkOutput("discardStuck", {7'b0, stuckError}, 8'h00);

    sendByte(8'hA5);
    checkOutput("bp1Valid", {7'b0, dataValid}, 8'h01);
    checkOutput("bp1Data", dataOut, 8'hA5);
    sendByte(8'h3C);
    checkOutput("bp2Data", dataOut, 8'hA5);
    sendEmit(1'b0);
    sendEmit(1'b0);
    checkOutput("bpHoldValid", {7'b0, dataValid}, 8'h01);
    checkOutput("bpHoldData", dataOut, 8'hA5);
    acceptPair("acceptA5", 1'b1, 8'h3C);
    acceptPair("accept3C", 1'b0, 8'h00);

    repeat (5) sendEmit(1'b1);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stopEnable", {7'b0, roEnable}, 8'h00);
    checkOutput("stopValid", {7'b0, dataValid}, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    startSession("s2");
    sendByte(8'h0F);
    checkOutput("restartValid", {7'b0, dataValid}, 8'h01);
    checkOutput("restartData", dataOut, 8'h0F);

    repeat (63) applyStimulus(1'b1);
    checkOutput("preStuckError", {7'b0, stuckError}, 8'h00);
    checkOutput("preStuckEnable", {7'b0, roEnable}, 8'h01);
    checkOutput("preStuckValid", {7'b0, dataValid}, 8'h01);
    applyStimulus(1'b1);
    checkOutput("stuckError", {7'b0, stuckError}, 8'h01);
    checkOutput("stuckEnable", {7'b0, roEnable}, 8'h00);
    checkOutput("stuckValid", {7'b0, dataValid}, 8'h00);
    start = 1'b0;
    repeat (5) @(posedge clk);
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("errorStickyError", {7'b0, stuckError}, 8'h01);
    checkOutput("errorStickyEnable", {7'b0, roEnable}, 8'h00);

    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstError", {7'b0, stuckError}, 8'h00);
    checkOutput("asyncRstEnable", {7'b0, roEnable}, 8'h00);
    checkOutput("asyncRstValid", {7'b0, dataValid}, 8'h00);
    checkOutput("asyncRstData", dataOut, 8'h00);
    repeat (3) begin
      @(negedge clk);
      roIn = roIn ^ 4'b0110;
    end
    @(negedge clk);
    rst_n = 1'b1;

    startSession("s3");
    sendEmit(1'b1);
    sendEmit(1'b1);
    sendEmit(1'b0);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    startSession("s4");
    sendByte(8'hC3);
    checkOutput("midRstValid", {7'b0, dataValid}, 8'h01);
    checkOutput("midRstData", dataOut, 8'hC3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
